// File: rtl/pix_clk_ctrl.sv
// pix_clk_ctrl: pixel-clock sequencer. It divides clk125 into a registered divided
// clock and a one-cycle pixel clock-enable. Divide ratio and high time can be changed
// at runtime. A change is applied only at a period boundary, so no runt pulse appears.
module pix_clk_ctrl #(
    parameter int unsigned DIV_W    = 4,
    parameter int unsigned DEF_DIV  = 5,
    parameter int unsigned DEF_HIGH = 2
) (
    input  logic             clk125,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_high,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_clk,
    output logic             pix_ce,
    output logic             locked,
    output logic             busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic [DIV_W-1:0] high_act_q, high_act_d;
    logic [DIV_W-1:0] div_pnd_q, div_pnd_d;
    logic [DIV_W-1:0] high_pnd_q, high_pnd_d;
    logic             pnd_q, pnd_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             div_clk_q, div_clk_d;
    logic             pix_ce_q, pix_ce_d;

    logic xfer;
    logic legal;
    logic wrap;

    assign cfg_ready = !pnd_q && !rst;
    assign xfer      = cfg_valid && cfg_ready;
    assign legal     = (cfg_div >= DIV_W'(2)) && (cfg_high >= DIV_W'(1)) &&
                       (cfg_high <= (cfg_div - DIV_W'(1)));
    assign wrap      = (cnt_q == (div_act_q - DIV_W'(1)));

    assign cfg_err = err_q;
    assign div_clk = div_clk_q;
    assign pix_ce  = pix_ce_q;
    assign locked  = locked_q;
    assign busy    = (state_q != S_IDLE);

    // Next-state logic: config capture, period counting, apply/stop at the wrap.
    // Outputs are derived from the post-update counter and active config, so a new
    // high time takes effect from the first cycle of the new period.
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        div_act_d  = div_act_q;
        high_act_d = high_act_q;
        div_pnd_d  = div_pnd_q;
        high_pnd_d = high_pnd_q;
        pnd_d      = pnd_q;
        locked_d   = locked_q;
        err_d      = xfer && !legal;

        // A transfer can only happen while nothing is pending, so it never
        // collides with an apply in the same cycle.
        if (xfer && legal) begin
            div_pnd_d  = cfg_div;
            high_pnd_d = cfg_high;
            pnd_d      = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                locked_d = 1'b0;
                if (pnd_q) begin
                    div_act_d  = div_pnd_q;
                    high_act_d = high_pnd_q;
                    pnd_d      = 1'b0;
                end else if (run) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (wrap) begin
                    cnt_d = '0;
                    if (pnd_q) begin
                        div_act_d  = div_pnd_q;
                        high_act_d = high_pnd_q;
                        pnd_d      = 1'b0;
                        locked_d   = 1'b0;
                    end
                    if (!run) begin
                        state_d  = S_IDLE;
                        locked_d = 1'b0;
                    end else if (!pnd_q) begin
                        locked_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        div_clk_d = (state_d == S_RUN) && (cnt_d < high_act_d);
        pix_ce_d  = (state_d == S_RUN) && (cnt_d == '0);
    end

    // State and output registers with synchronous reset; reset drops any pending config.
    always_ff @(posedge clk125) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_act_q  <= DIV_W'(DEF_DIV);
            high_act_q <= DIV_W'(DEF_HIGH);
            div_pnd_q  <= '0;
            high_pnd_q <= '0;
            pnd_q      <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            div_clk_q  <= 1'b0;
            pix_ce_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            high_act_q <= high_act_d;
            div_pnd_q  <= div_pnd_d;
            high_pnd_q <= high_pnd_d;
            pnd_q      <= pnd_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            div_clk_q  <= div_clk_d;
            pix_ce_q   <= pix_ce_d;
        end
    end

endmodule
